// File: rtl/int_controller_n_if.sv
// Peripheral/CPU interrupt bundle for int_controller_n.
// Mask signals exist only when INTC_MASK_EN is defined.
interface int_controller_n_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ID_W   = 2
);
  logic [NUM_CH-1:0] pIrq;
  logic [NUM_CH-1:0] pIack;
  logic [NUM_CH-1:0] pIend;
  logic              irq;
  logic [ID_W-1:0]   irqId;
  logic              iack;
  logic              iend;
  logic              busy;
`ifdef INTC_MASK_EN
  logic              maskWe;
  logic [NUM_CH-1:0] maskWdata;
  logic [NUM_CH-1:0] mask;
`endif

  // Controller side
  modport master (
    input  pIrq, iack, iend,
`ifdef INTC_MASK_EN
    input  maskWe, maskWdata,
    output mask,
`endif
    output pIack, pIend, irq, irqId, busy
  );

  // Peripheral/CPU side
  modport slave (
    output pIrq, iack, iend,
`ifdef INTC_MASK_EN
    output maskWe, maskWdata,
    input  mask,
`endif
    input  pIack, pIend, irq, irqId, busy
  );
endinterface

// File: rtl/int_controller_n.sv
// N-channel fixed-priority interrupt controller with a single in-service handshake.
// Define INTC_MASK_EN to add the per-channel mask register.
module int_controller_n #(
  parameter int unsigned       NUM_CH    = 4,
  parameter int unsigned       ID_W      = 2,
  parameter logic [NUM_CH-1:0] TRIG_EDGE = {NUM_CH{1'b1}}
) (
  input logic                CLK,
  input logic                RESET,
  int_controller_n_if.master bus
);

  typedef enum logic [1:0] {StIdle, StReq, StSvc} state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] pirq_q, pirq_prev_q;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] pack_q, pack_d;
  logic [NUM_CH-1:0] pend_out_q, pend_out_d;
  logic [NUM_CH-1:0] mask_w, rise, ready, clr, id_oh;
  logic [ID_W-1:0]   id_q, id_d, win_id;
  logic              win_vld;
  logic              irq_q, irq_d, busy_q, busy_d;

`ifdef INTC_MASK_EN
  logic [NUM_CH-1:0] mask_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask_q <= '0;
    end else if (bus.maskWe) begin
      mask_q <= bus.maskWdata;
    end
  end

  assign mask_w   = mask_q;
  assign bus.mask = mask_q;
`else
  assign mask_w = '0;
`endif

  // Level channels bypass the pending latch and follow the registered input.
  assign rise  = pirq_q & ~pirq_prev_q;
  assign ready = ((pend_q & TRIG_EDGE) | (pirq_q & ~TRIG_EDGE)) & ~mask_w;
  assign id_oh = NUM_CH'(1) << id_q;

  // Lowest index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    clr        = '0;
    pack_d     = '0;
    pend_out_d = '0;
    case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d = StReq;
          id_d    = win_id;
        end
      end
      StReq: begin
        if (bus.iack) begin
          state_d = StSvc;
          pack_d  = id_oh;
          clr     = id_oh;
        end
      end
      StSvc: begin
        if (bus.iend) begin
          state_d    = StIdle;
          pend_out_d = id_oh;
        end
      end
      default: state_d = StIdle;
    endcase
    // A new edge in the same cycle as the clear stays pending.
    pend_d = ((pend_q & ~clr) | rise) & TRIG_EDGE;
    irq_d  = (state_d == StReq);
    busy_d = (state_d == StSvc);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      pirq_q      <= '0;
      pirq_prev_q <= '0;
      pend_q      <= '0;
      pack_q      <= '0;
      pend_out_q  <= '0;
      id_q        <= '0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pirq_q      <= bus.pIrq;
      pirq_prev_q <= pirq_q;
      pend_q      <= pend_d;
      pack_q      <= pack_d;
      pend_out_q  <= pend_out_d;
      id_q        <= id_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.irq   = irq_q;
  assign bus.busy  = busy_q;
  assign bus.irqId = id_q;
  assign bus.pIack = pack_q;
  assign bus.pIend = pend_out_q;

endmodule

// File: tb/tb_int_controller_n.sv
// Bench for int_controller_n: two instances (all-edge, and channel 0 level) checked
// against a behavioural model every cycle, plus directed literal checks.
module tb_int_controller_n;
  localparam int unsigned NC = 4;
  localparam int unsigned IW = 2;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  int_controller_n_if #(.NUM_CH(NC), .ID_W(IW)) ifa ();
  int_controller_n_if #(.NUM_CH(NC), .ID_W(IW)) ifb ();

  int_controller_n #(.NUM_CH(NC), .ID_W(IW), .TRIG_EDGE(4'b1111)) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(ifa)
  );
  int_controller_n #(.NUM_CH(NC), .ID_W(IW), .TRIG_EDGE(4'b1110)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(ifb)
  );

  always #5 CLK = ~CLK;

  logic [3:0] mask_a, mask_b, mwd_a, mwd_b;
  logic       mwe_a, mwe_b;
`ifdef INTC_MASK_EN
  assign mask_a = ifa.mask;
  assign mask_b = ifb.mask;
  assign mwe_a  = ifa.maskWe;
  assign mwe_b  = ifb.maskWe;
  assign mwd_a  = ifa.maskWdata;
  assign mwd_b  = ifb.maskWdata;
`else
  assign mask_a = 4'b0;
  assign mask_b = 4'b0;
  assign mwe_a  = 1'b0;
  assign mwe_b  = 1'b0;
  assign mwd_a  = 4'b0;
  assign mwd_b  = 4'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner channel, phase (0 none, 1 requested, 2 in service), input history.
  logic [3:0] m_in1[2], m_in2[2], m_pend[2], m_mask[2], e_pack[2], e_pend[2];
  int         m_phase[2], m_cur[2];

  function automatic int lowest(input logic [3:0] r);
    for (int c = 0; c < 4; c++) if (r[c]) return c;
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_in1[m] = '0; m_in2[m] = '0; m_pend[m] = '0; m_mask[m] = '0;
      e_pack[m] = '0; e_pend[m] = '0; m_phase[m] = 0; m_cur[m] = 0;
    end
  endtask

  task automatic model_step(input int m, input logic [3:0] pirq, input logic ack,
                            input logic fin, input logic mwe, input logic [3:0] mwd);
    logic [3:0] trig, rise, ready, clr;
    trig   = (m == 0) ? 4'b1111 : 4'b1110;
    rise   = m_in1[m] & ~m_in2[m];
    ready  = ((m_pend[m] & trig) | (m_in1[m] & ~trig)) & ~m_mask[m];
    clr    = '0;
    e_pack[m] = '0;
    e_pend[m] = '0;
    if (m_phase[m] == 0) begin
      if (ready != 0) begin
        m_cur[m]   = lowest(ready);
        m_phase[m] = 1;
      end
    end else if (m_phase[m] == 1) begin
      if (ack) begin
        m_phase[m] = 2;
        e_pack[m]  = 4'b0001 << m_cur[m];
        clr        = e_pack[m];
      end
    end else if (fin) begin
      m_phase[m] = 0;
      e_pend[m]  = 4'b0001 << m_cur[m];
    end
    m_pend[m] = ((m_pend[m] & ~clr) | rise) & trig;
    m_in2[m]  = m_in1[m];
    m_in1[m]  = pirq;
    if (mwe) m_mask[m] = mwd;
  endtask

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      model_reset();
    end else begin
      model_step(0, ifa.pIrq, ifa.iack, ifa.iend, mwe_a, mwd_a);
      model_step(1, ifb.pIrq, ifb.iack, ifb.iend, mwe_b, mwd_b);
    end
  end

  task automatic cmp_one(input int m, input string p, input logic irq, input logic busy,
                         input logic [3:0] pack, input logic [3:0] pend,
                         input logic [1:0] id, input logic [3:0] msk);
    chk({p, ".irq"}, 32'(irq), 32'(m_phase[m] == 1));
    chk({p, ".busy"}, 32'(busy), 32'(m_phase[m] == 2));
    chk({p, ".pIack"}, 32'(pack), 32'(e_pack[m]));
    chk({p, ".pIend"}, 32'(pend), 32'(e_pend[m]));
    chk({p, ".mask"}, 32'(msk), 32'(m_mask[m]));
    if (m_phase[m] != 0) chk({p, ".irqId"}, 32'(id), 32'(m_cur[m]));
  endtask

  always @(negedge CLK) begin
    cmp_one(0, "a", ifa.irq, ifa.busy, ifa.pIack, ifa.pIend, ifa.irqId, mask_a);
    cmp_one(1, "b", ifb.irq, ifb.busy, ifb.pIack, ifb.pIend, ifb.irqId, mask_b);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input int m, input logic [3:0] v);
    if (m == 0) ifa.pIrq = v; else ifb.pIrq = v;
  endtask
  task automatic set_ack(input int m, input logic v);
    if (m == 0) ifa.iack = v; else ifb.iack = v;
  endtask
  task automatic set_end(input int m, input logic v);
    if (m == 0) ifa.iend = v; else ifb.iend = v;
  endtask
  function automatic logic get_irq(input int m);
    return (m == 0) ? ifa.irq : ifb.irq;
  endfunction
  function automatic logic [1:0] get_id(input int m);
    return (m == 0) ? ifa.irqId : ifb.irqId;
  endfunction

  task automatic wait_irq(input int m, input int maxc, output int n);
    n = 0;
    while (!get_irq(m) && n < maxc) begin
      tick();
      n++;
    end
    if (!get_irq(m)) begin
      checks++;
      failures++;
      $display("FAIL wait_irq: no request within %0d cycles on instance %0d", maxc, m);
    end
  endtask

  task automatic serve(input int m);
    set_ack(m, 1'b1); tick(); set_ack(m, 1'b0);
    tick();
    set_end(m, 1'b1); tick(); set_end(m, 1'b0);
  endtask

`ifdef INTC_MASK_EN
  task automatic write_mask(input logic [3:0] v);
    ifa.maskWe = 1'b1; ifa.maskWdata = v; tick(); ifa.maskWe = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, cnt;
    logic seen;
    ifa.pIrq = '0; ifa.iack = 1'b0; ifa.iend = 1'b0;
    ifb.pIrq = '0; ifb.iack = 1'b0; ifb.iend = 1'b0;
`ifdef INTC_MASK_EN
    ifa.maskWe = 1'b0; ifa.maskWdata = '0;
    ifb.maskWe = 1'b0; ifb.maskWdata = '0;
`endif
    repeat (3) tick();
    chk("rst_irq", 32'(ifa.irq), 0);
    chk("rst_busy", 32'(ifa.busy), 0);
    chk("rst_id", 32'(ifa.irqId), 0);
    chk("rst_pIack", 32'(ifb.pIack), 0);
    RESET = 1'b0;
    tick();

    // Single edge request on channel 2
    set_in(0, 4'b0100); tick(); set_in(0, 4'b0000);
    wait_irq(0, 10, n);
    chk("t1_latency", 32'(n + 1), 3);
    chk("t1_id", 32'(ifa.irqId), 2);
    set_ack(0, 1'b1); tick(); set_ack(0, 1'b0);
    chk("t1_busy", 32'(ifa.busy), 1);
    chk("t1_pIack", 32'(ifa.pIack), 32'h4);
    tick();
    chk("t1_pIack_off", 32'(ifa.pIack), 0);
    set_end(0, 1'b1); tick(); set_end(0, 1'b0);
    chk("t1_pIend", 32'(ifa.pIend), 32'h4);
    chk("t1_busy_off", 32'(ifa.busy), 0);
    tick();
    chk("t1_pIend_off", 32'(ifa.pIend), 0);

    // Priority: 3 and 1 together
    set_in(0, 4'b1010); tick(); set_in(0, 4'b0000);
    wait_irq(0, 10, n);
    chk("t2_first", 32'(ifa.irqId), 1);
    serve(0);
    chk("t2_gap", 32'(ifa.irq), 0);
    wait_irq(0, 10, n);
    chk("t2_gap_len", 32'(n), 1);
    chk("t2_second", 32'(ifa.irqId), 3);
    serve(0);
    tick();

    // No preemption
    set_in(0, 4'b0100); tick(); set_in(0, 4'b0000);
    wait_irq(0, 10, n);
    set_ack(0, 1'b1); tick(); set_ack(0, 1'b0);
    set_in(0, 4'b0001); tick(); set_in(0, 4'b0000);
    repeat (4) tick();
    chk("t3_id_held", 32'(ifa.irqId), 2);
    chk("t3_busy_held", 32'(ifa.busy), 1);
    set_end(0, 1'b1); tick(); set_end(0, 1'b0);
    wait_irq(0, 10, n);
    chk("t3_next", 32'(ifa.irqId), 0);
    serve(0);
    tick();

    // Level channel 0 vs edge channel 1 on instance b
    set_in(1, 4'b0001);
    wait_irq(1, 10, n);
    chk("t4_level_latency", 32'(n), 2);
    chk("t4_id0_a", 32'(ifb.irqId), 0);
    serve(1);
    wait_irq(1, 10, n);
    chk("t4_id0_b", 32'(ifb.irqId), 0);
    set_ack(1, 1'b1); tick(); set_ack(1, 1'b0);
    set_in(1, 4'b0000); tick();
    set_end(1, 1'b1); tick(); set_end(1, 1'b0);
    set_in(1, 4'b0010);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (get_irq(1)) begin
        cnt++;
        chk("t4_id1", 32'(get_id(1)), 1);
        serve(1);
      end
    end
    chk("t4_edge_once", 32'(cnt), 1);
    set_in(1, 4'b0000);
    repeat (3) tick();

`ifdef INTC_MASK_EN
    write_mask(4'b0010);
    set_in(0, 4'b0010); tick(); set_in(0, 4'b0000);
    repeat (6) tick();
    chk("t5_masked", 32'(ifa.irq), 0);
    write_mask(4'b0000);
    wait_irq(0, 10, n);
    chk("t5_unmask_lat", 32'(n), 1);
    chk("t5_unmask_id", 32'(ifa.irqId), 1);
    write_mask(4'b0010);
    chk("t5_held", 32'(ifa.irq), 1);
    serve(0);
    write_mask(4'b0000);
    tick();
`endif

    // Reset mid-service with another request pending
    set_in(0, 4'b0100); tick(); set_in(0, 4'b0000);
    wait_irq(0, 10, n);
    set_in(0, 4'b0001); tick(); set_in(0, 4'b0000); tick();
    set_ack(0, 1'b1); tick(); set_ack(0, 1'b0);
    #1 RESET = 1'b1;
    #1;
    chk("t6_irq", 32'(ifa.irq), 0);
    chk("t6_busy", 32'(ifa.busy), 0);
    chk("t6_pIack", 32'(ifa.pIack), 0);
    chk("t6_pIend", 32'(ifa.pIend), 0);
    tick(); tick();
    RESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifa.irq || ifa.busy || ifa.pIend != 0) seen = 1'b1;
    end
    chk("t6_idle_after", 32'(seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
